// File: rtl/spi_cmd_responder_if.sv
// Memory-map bus between the SPI command responder (master) and the register file (slave).
interface spi_cmd_responder_if #(
  parameter int unsigned ADDR_W = 8
);
  logic [ADDR_W-1:0] mem_addr;
  logic [15:0]       mem_wdata;
  logic              mem_we;
  logic              mem_re;
  logic [15:0]       mem_rdata;

  modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_rdata);
  modport slave  (input mem_addr, mem_wdata, mem_we, mem_re, output mem_rdata);
endinterface

// File: rtl/spi_cmd_responder.sv
// SPI mode-3 command responder: decodes CMD/ADDR/DATA frames into memory-map strobes and enable pulses.
// Optional readback path (ADDR_RD/DATA_RD, mem_re, MISO shifter) enabled by SPI_RESP_READBACK_EN.
`ifndef C_MEM_WR
`define C_MEM_WR 16'h0057
`endif
`ifndef C_MEM_RD
`define C_MEM_RD 16'h0052
`endif
`ifndef C_EN_SET
`define C_EN_SET 16'h0045
`endif
`ifndef C_EN_CLR
`define C_EN_CLR 16'h0044
`endif

module spi_cmd_responder #(
  parameter int unsigned ADDR_W  = 8,
  parameter int unsigned SYNC_FF = 2
) (
  input  logic                CLK_EXT,
  input  logic                ENABLE,
  input  logic                spi_clk,
  input  logic                spi_mosi,
  input  logic                spi_csn,
  output logic                spi_miso,
  spi_cmd_responder_if.master mem,
  output logic                en_set,
  output logic                en_clr,
  output logic                frame_err
);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_WR, DATA_WR, ADDR_RD, DATA_RD, IGNORE
  } state_t;

  logic [SYNC_FF-1:0] sck_sync_q, csn_sync_q, mosi_sync_q;
  logic               sck_prev_q, csn_prev_q;
  logic               sck_s, csn_s, mosi_s;
  logic               sck_rise, sck_fall, csn_rise, csn_fall;

  logic [15:0]        rx_sr_q;
  logic [3:0]         bit_cnt_q;
  logic               word_done_q;

  state_t             state_q;
  logic [ADDR_W-1:0]  mem_addr_q;
  logic [15:0]        mem_wdata_q;
  logic               mem_we_q;
  logic               en_set_q, en_clr_q, frame_err_q;

  // Synchronisers; sck/csn preset high so reset release never looks like an edge
  always_ff @(posedge CLK_EXT or negedge ENABLE) begin
    if (!ENABLE) begin
      sck_sync_q  <= '1;
      csn_sync_q  <= '1;
      mosi_sync_q <= '0;
      sck_prev_q  <= 1'b1;
      csn_prev_q  <= 1'b1;
    end else begin
      sck_sync_q  <= {sck_sync_q[SYNC_FF-2:0], spi_clk};
      csn_sync_q  <= {csn_sync_q[SYNC_FF-2:0], spi_csn};
      mosi_sync_q <= {mosi_sync_q[SYNC_FF-2:0], spi_mosi};
      sck_prev_q  <= sck_sync_q[SYNC_FF-1];
      csn_prev_q  <= csn_sync_q[SYNC_FF-1];
    end
  end

  assign sck_s    = sck_sync_q[SYNC_FF-1];
  assign csn_s    = csn_sync_q[SYNC_FF-1];
  assign mosi_s   = mosi_sync_q[SYNC_FF-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign sck_fall = ~sck_s & sck_prev_q;
  assign csn_rise = csn_s & ~csn_prev_q;
  assign csn_fall = ~csn_s & csn_prev_q;

  // Receive shifter; word_done pulses the clk after the 16th rising edge
  always_ff @(posedge CLK_EXT or negedge ENABLE) begin
    if (!ENABLE) begin
      rx_sr_q     <= '0;
      bit_cnt_q   <= '0;
      word_done_q <= 1'b0;
    end else begin
      word_done_q <= 1'b0;
      if (csn_fall) begin
        bit_cnt_q <= '0;
      end else if (sck_rise && !csn_s) begin
        rx_sr_q     <= {rx_sr_q[14:0], mosi_s};
        bit_cnt_q   <= bit_cnt_q + 4'd1;
        word_done_q <= (bit_cnt_q == 4'd15);
      end
    end
  end

`ifdef SPI_RESP_READBACK_EN
  logic        mem_re_q;
  logic        rd_load_q;
  logic [15:0] tx_sr_q;
`endif

  // Frame decoder; a completed word is acted on even if csn rises in the same clk
  always_ff @(posedge CLK_EXT or negedge ENABLE) begin
    if (!ENABLE) begin
      state_q     <= IDLE;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      mem_we_q    <= 1'b0;
      en_set_q    <= 1'b0;
      en_clr_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPI_RESP_READBACK_EN
      mem_re_q    <= 1'b0;
`endif
    end else begin
      mem_we_q    <= 1'b0;
      en_set_q    <= 1'b0;
      en_clr_q    <= 1'b0;
      frame_err_q <= 1'b0;
`ifdef SPI_RESP_READBACK_EN
      mem_re_q    <= 1'b0;
`endif
      if (mem_we_q) mem_addr_q <= mem_addr_q + ADDR_W'(1);

      if (word_done_q) begin
        case (state_q)
          CMD: begin
            case (rx_sr_q)
              `C_MEM_WR: state_q <= ADDR_WR;
`ifdef SPI_RESP_READBACK_EN
              `C_MEM_RD: state_q <= ADDR_RD;
`endif
              `C_EN_SET: begin
                en_set_q <= 1'b1;
                state_q  <= IGNORE;
              end
              `C_EN_CLR: begin
                en_clr_q <= 1'b1;
                state_q  <= IGNORE;
              end
              default: begin
                frame_err_q <= 1'b1;
                state_q     <= IGNORE;
              end
            endcase
          end
          ADDR_WR: begin
            mem_addr_q <= rx_sr_q[ADDR_W-1:0];
            state_q    <= DATA_WR;
          end
          DATA_WR: begin
            mem_wdata_q <= rx_sr_q;
            mem_we_q    <= 1'b1;
          end
`ifdef SPI_RESP_READBACK_EN
          ADDR_RD: begin
            mem_addr_q <= rx_sr_q[ADDR_W-1:0];
            mem_re_q   <= 1'b1;
            state_q    <= DATA_RD;
          end
          DATA_RD: begin
            mem_addr_q <= mem_addr_q + ADDR_W'(1);
            mem_re_q   <= 1'b1;
          end
`endif
          default: ;
        endcase
      end

      if (csn_fall) begin
        state_q <= CMD;
      end else if (csn_rise) begin
        state_q <= IDLE;
        if (bit_cnt_q != 4'd0) frame_err_q <= 1'b1;
      end
    end
  end

`ifdef SPI_RESP_READBACK_EN
  // MISO shifter: loads read data two clks after mem_re, shifts on falls after the first
  always_ff @(posedge CLK_EXT or negedge ENABLE) begin
    if (!ENABLE) begin
      tx_sr_q   <= '0;
      rd_load_q <= 1'b0;
    end else begin
      rd_load_q <= mem_re_q;
      if (state_q != DATA_RD)                          tx_sr_q <= '0;
      else if (rd_load_q)                              tx_sr_q <= mem.mem_rdata;
      else if (sck_fall && !csn_s && bit_cnt_q != 4'd0) tx_sr_q <= {tx_sr_q[14:0], 1'b0};
    end
  end

  assign mem.mem_re = mem_re_q;
  assign spi_miso   = tx_sr_q[15];
`else
  assign mem.mem_re = 1'b0;
  assign spi_miso   = 1'b0;
`endif

  assign mem.mem_addr  = mem_addr_q;
  assign mem.mem_wdata = mem_wdata_q;
  assign mem.mem_we    = mem_we_q;
  assign en_set        = en_set_q;
  assign en_clr        = en_clr_q;
  assign frame_err     = frame_err_q;

endmodule
